// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the multi-channel SPI control register bank:
// field positions, default write masks and per-channel state encoding.
package spi_ctrl_pkg;

    localparam int unsigned SendBit   = 0;
    localparam int unsigned CsCtrlBit = 1;
    localparam int unsigned All1sBit  = 2;
    localparam int unsigned All0sBit  = 3;
    localparam int unsigned NTxEndLsb = 4;
    localparam int unsigned NTxEndW   = 9;
    localparam int unsigned NRxEndLsb = 16;
    localparam int unsigned NRxEndW   = 10;

    localparam logic [31:0] HostWmaskDef = 32'h03FF_1FFE;
    localparam logic [31:0] SpiWmaskDef  = 32'h03FF_0000;

    typedef logic [1:0] ch_state_e;
    localparam ch_state_e StIdle   = 2'd0;
    localparam ch_state_e StPend   = 2'd1;
    localparam ch_state_e StActive = 2'd2;

endpackage

// File: rtl/spi_ctrl_reg_bank_if.sv
// Host bus, SPI engine write port, start handshake and completion signals of
// the register bank; slave is the bank's view, master the surrounding logic.
interface spi_ctrl_reg_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              host_we_i;
    logic [CH_W-1:0]   host_ch_i;
    logic [DATA_W-1:0] host_data_i;
    logic              host_err_o;
    logic [CH_W-1:0]   rd_ch_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              spi_we_i;
    logic [CH_W-1:0]   spi_ch_i;
    logic [DATA_W-1:0] spi_data_i;
    logic              start_valid_o;
    logic              start_ready_i;
    logic [CH_W-1:0]   start_ch_o;
    logic [DATA_W-1:0] start_cfg_o;
    logic              done_i;
    logic              done_o;
    logic [CH_W-1:0]   done_ch_o;
    logic [NUM_CH-1:0] busy_o;

    modport slave (
        input  host_we_i, host_ch_i, host_data_i, rd_ch_i, spi_we_i, spi_ch_i, spi_data_i,
               start_ready_i, done_i,
        output host_err_o, rd_data_o, start_valid_o, start_ch_o, start_cfg_o, done_o,
               done_ch_o, busy_o
    );

    modport master (
        output host_we_i, host_ch_i, host_data_i, rd_ch_i, spi_we_i, spi_ch_i, spi_data_i,
               start_ready_i, done_i,
        input  host_err_o, rd_data_o, start_valid_o, start_ch_o, start_cfg_o, done_o,
               done_ch_o, busy_o
    );

endinterface

// File: rtl/spi_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr_i,
// wrapping at NUM_CH.
module spi_ctrl_rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              found_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(ptr_i) + i) % NUM_CH;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (!found_o && (c == idx) && req_i[c]) begin
                    found_o = 1'b1;
                    grant_o = CH_W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/spi_ctrl_reg_bank.sv
// Per-channel SPI control/status registers sharing one SPI engine: host arms a
// channel with SEND, a round-robin scheduler offers it, engine done clears it.
module spi_ctrl_reg_bank
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 4,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] HOST_WMASK = DATA_W'(HostWmaskDef),
    parameter logic [DATA_W-1:0] SPI_WMASK  = DATA_W'(SpiWmaskDef)
) (
    input logic                clk_i,
    input logic                reset_i,
    spi_ctrl_reg_bank_if.slave bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // SEND has its own path; neither mask may touch it directly.
    localparam logic [DATA_W-1:0] HostMask = HOST_WMASK & ~DATA_W'(1);
    localparam logic [DATA_W-1:0] SpiMask  = SPI_WMASK & ~DATA_W'(1);

    logic [DATA_W-1:0] regs_q [NUM_CH];
    logic [DATA_W-1:0] regs_d [NUM_CH];
    ch_state_e         st_q   [NUM_CH];
    ch_state_e         st_d   [NUM_CH];

    logic              offer_valid_q, offer_valid_d;
    logic [CH_W-1:0]   offer_ch_q, offer_ch_d;
    logic [DATA_W-1:0] offer_cfg_q, offer_cfg_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              done_q, done_d;
    logic [CH_W-1:0]   done_ch_q, done_ch_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_q, rd_d;

    logic [NUM_CH-1:0] pend_req;
    logic              any_active;
    logic              host_ok;
    logic [CH_W-1:0]   grant;
    logic              found;
    logic [DATA_W-1:0] grant_cfg;

    always_comb begin
        pend_req   = '0;
        any_active = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pend_req[c] = (st_q[c] == StPend);
            if (st_q[c] == StActive) any_active = 1'b1;
        end
    end

    spi_ctrl_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req_i   (pend_req),
        .ptr_i   (rr_q),
        .grant_o (grant),
        .found_o (found)
    );

    always_comb begin
        regs_d        = regs_q;
        st_d          = st_q;
        host_ok       = 1'b0;
        done_d        = 1'b0;
        done_ch_d     = done_ch_q;
        offer_valid_d = offer_valid_q;
        offer_ch_d    = offer_ch_q;
        offer_cfg_d   = offer_cfg_q;
        rr_d          = rr_q;
        rd_d          = '0;
        grant_cfg     = '0;

        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if ((32'(bus.host_ch_i) == c) && (st_q[c] == StIdle)) host_ok = 1'b1;

            if (bus.host_we_i && (32'(bus.host_ch_i) == c) && (st_q[c] == StIdle)) begin
                regs_d[c] = (regs_q[c] & ~HostMask) | (bus.host_data_i & HostMask);
                regs_d[c][SendBit] = bus.host_data_i[SendBit];
                if (bus.host_data_i[SendBit]) st_d[c] = StPend;
            end

            // Applied after the host merge so the engine wins any overlapping bit.
            if (bus.spi_we_i && (32'(bus.spi_ch_i) == c)) begin
                regs_d[c] = (regs_d[c] & ~SpiMask) | (bus.spi_data_i & SpiMask);
            end

            if (bus.done_i && (st_q[c] == StActive)) begin
                st_d[c]            = StIdle;
                regs_d[c][SendBit] = 1'b0;
                done_d             = 1'b1;
                done_ch_d          = CH_W'(c);
            end

            if (offer_valid_q && bus.start_ready_i && (32'(offer_ch_q) == c)) st_d[c] = StActive;

            if (32'(bus.rd_ch_i) == c) rd_d = regs_q[c];
            if (32'(grant) == c) grant_cfg = regs_q[c];
        end

        err_d = bus.host_we_i && !host_ok;

        if (offer_valid_q) begin
            if (bus.start_ready_i) begin
                offer_valid_d = 1'b0;
                rr_d = (32'(offer_ch_q) == NUM_CH - 1) ? '0 : offer_ch_q + 1'b1;
            end
        end else if (!any_active && found) begin
            offer_valid_d = 1'b1;
            offer_ch_d    = grant;
            offer_cfg_d   = grant_cfg;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                regs_q[c] <= '0;
                st_q[c]   <= StIdle;
            end
            offer_valid_q <= 1'b0;
            offer_ch_q    <= '0;
            offer_cfg_q   <= '0;
            rr_q          <= '0;
            done_q        <= 1'b0;
            done_ch_q     <= '0;
            err_q         <= 1'b0;
            rd_q          <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                regs_q[c] <= regs_d[c];
                st_q[c]   <= st_d[c];
            end
            offer_valid_q <= offer_valid_d;
            offer_ch_q    <= offer_ch_d;
            offer_cfg_q   <= offer_cfg_d;
            rr_q          <= rr_d;
            done_q        <= done_d;
            done_ch_q     <= done_ch_d;
            err_q         <= err_d;
            rd_q          <= rd_d;
        end
    end

    always_comb begin
        bus.busy_o = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            bus.busy_o[c] = (st_q[c] != StIdle);
        end
    end

    assign bus.host_err_o    = err_q;
    assign bus.rd_data_o     = rd_q;
    assign bus.start_valid_o = offer_valid_q;
    assign bus.start_ch_o    = offer_ch_q;
    assign bus.start_cfg_o   = offer_cfg_q;
    assign bus.done_o        = done_q;
    assign bus.done_ch_o     = done_ch_q;

endmodule

// File: tb/tb_spi_ctrl_reg_bank.sv
// Bench for spi_ctrl_reg_bank: directed scenarios plus random traffic, all
// compared cycle by cycle against a behavioural model of the channel rules.
module tb_spi_ctrl_reg_bank;

    localparam int NUM_CH = 4;
    localparam logic [31:0] HM = 32'h03FF_1FFE;
    localparam logic [31:0] SM = 32'h03FF_0000;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    spi_ctrl_reg_bank_if #(.NUM_CH(4), .DATA_W(32)) bus ();
    spi_ctrl_reg_bank_if #(.NUM_CH(3), .DATA_W(32)) bus3 ();

    spi_ctrl_reg_bank #(.NUM_CH(4), .DATA_W(32)) u_dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    spi_ctrl_reg_bank #(.NUM_CH(3), .DATA_W(32)) u_dut3 (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Reference model state
    logic [31:0] m_reg [NUM_CH];
    bit          m_pend [NUM_CH];
    bit          m_act;
    int          m_act_ch;
    bit          m_ov;
    int          m_och;
    logic [31:0] m_ocfg;
    int          m_rr;
    bit          m_done;
    int          m_done_ch;
    bit          m_err;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_reg[c]  = '0;
            m_pend[c] = 1'b0;
        end
        m_act = 0; m_act_ch = 0; m_ov = 0; m_och = 0; m_ocfg = '0; m_rr = 0;
        m_done = 0; m_done_ch = 0; m_err = 0; m_rd = '0;
    endtask

    task automatic model_edge();
        logic [31:0] nr [NUM_CH];
        bit          np [NUM_CH];
        bit          nact, nov;
        int          nact_ch, hc, sc, rc, idx;
        nr = m_reg; np = m_pend; nact = m_act; nact_ch = m_act_ch; nov = m_ov;

        rc   = int'(bus.rd_ch_i);
        m_rd = (rc < NUM_CH) ? m_reg[rc] : 32'h0;

        m_err = 1'b0;
        if (bus.host_we_i) begin
            hc = int'(bus.host_ch_i);
            if (hc < NUM_CH && !m_pend[hc] && !(m_act && m_act_ch == hc)) begin
                nr[hc] = (m_reg[hc] & ~(HM | 32'h1)) | (bus.host_data_i & HM)
                         | {31'h0, bus.host_data_i[0]};
                if (bus.host_data_i[0]) np[hc] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end

        if (bus.spi_we_i) begin
            sc = int'(bus.spi_ch_i);
            if (sc < NUM_CH) nr[sc] = (nr[sc] & ~SM) | (bus.spi_data_i & SM);
        end

        m_done = 1'b0;
        if (bus.done_i && m_act) begin
            nr[m_act_ch][0] = 1'b0;
            nact      = 1'b0;
            m_done    = 1'b1;
            m_done_ch = m_act_ch;
        end

        if (m_ov) begin
            if (bus.start_ready_i) begin
                nov = 1'b0; nact = 1'b1; nact_ch = m_och; np[m_och] = 1'b0;
                m_rr = (m_och + 1) % NUM_CH;
            end
        end else if (!m_act) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = (m_rr + i) % NUM_CH;
                if (!nov && m_pend[idx]) begin
                    nov = 1'b1; m_och = idx; m_ocfg = m_reg[idx];
                end
            end
        end

        m_reg = nr; m_pend = np; m_act = nact; m_act_ch = nact_ch; m_ov = nov;
    endtask

    task automatic compare_all();
        logic [3:0] eb;
        for (int c = 0; c < NUM_CH; c++) eb[c] = m_pend[c] | (m_act && m_act_ch == c);
        check("busy", 32'(bus.busy_o), 32'(eb));
        check("start_valid", 32'(bus.start_valid_o), 32'(m_ov));
        if (m_ov) begin
            check("start_ch", 32'(bus.start_ch_o), 32'(m_och));
            check("start_cfg", bus.start_cfg_o, m_ocfg);
        end
        check("done", 32'(bus.done_o), 32'(m_done));
        if (m_done) check("done_ch", 32'(bus.done_ch_o), 32'(m_done_ch));
        check("host_err", 32'(bus.host_err_o), 32'(m_err));
        check("rd_data", bus.rd_data_o, m_rd);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.host_we_i = 0; bus.host_ch_i = '0; bus.host_data_i = '0; bus.rd_ch_i = '0;
        bus.spi_we_i = 0; bus.spi_ch_i = '0; bus.spi_data_i = '0;
        bus.start_ready_i = 0; bus.done_i = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle_inputs();
        bus.start_ready_i = 1; bus.done_i = 1;
        while ((bus.busy_o != '0 || bus.start_valid_o) && n < 40) begin
            step();
            n++;
        end
        check("drain_idle", 32'(bus.busy_o), 32'h0);
        bus.start_ready_i = 0; bus.done_i = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[$];
        int exp_order[4];
        int cnt, n;
        bit rearmed;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 3; exp_order[3] = 0;

        rst_n = 1'b0;
        idle_inputs();
        bus3.host_we_i = 0; bus3.host_ch_i = '0; bus3.host_data_i = '0; bus3.rd_ch_i = '0;
        bus3.spi_we_i = 0; bus3.spi_ch_i = '0; bus3.spi_data_i = '0;
        bus3.start_ready_i = 0; bus3.done_i = 0;
        model_reset();
        #30;
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        check("rst_valid", 32'(bus.start_valid_o), 32'h0);
        check("rst_start_ch", 32'(bus.start_ch_o), 32'h0);
        check("rst_start_cfg", bus.start_cfg_o, 32'h0);
        check("rst_done", 32'(bus.done_o), 32'h0);
        check("rst_done_ch", 32'(bus.done_ch_o), 32'h0);
        check("rst_err", 32'(bus.host_err_o), 32'h0);
        check("rst_rd", bus.rd_data_o, 32'h0);
        #90 rst_n = 1'b1;

        // Single channel round trip
        bus.host_we_i = 1; bus.host_ch_i = 2'd2; bus.host_data_i = 32'h0000_0A31;
        step();
        check("t1_busy", 32'(bus.busy_o), 32'h4);
        bus.host_we_i = 0;
        step();
        check("t1_valid", 32'(bus.start_valid_o), 32'h1);
        check("t1_ch", 32'(bus.start_ch_o), 32'h2);
        check("t1_cfg", bus.start_cfg_o, 32'h0000_0A31);
        bus.start_ready_i = 1;
        step();
        check("t1_valid_drop", 32'(bus.start_valid_o), 32'h0);
        bus.start_ready_i = 0; bus.done_i = 1;
        step();
        check("t1_done", 32'(bus.done_o), 32'h1);
        check("t1_done_ch", 32'(bus.done_ch_o), 32'h2);
        bus.done_i = 0; bus.rd_ch_i = 2'd2;
        step();
        check("t1_rd", bus.rd_data_o, 32'h0000_0A30);
        check("t1_idle", 32'(bus.busy_o), 32'h0);

        // Round-robin order from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #5;
        model_reset();
        rst_n = 1'b1;
        bus.start_ready_i = 1;
        cnt = -1; rearmed = 0;
        for (int cyc = 0; cyc < 80 && grants.size() < 4; cyc++) begin
            bus.host_we_i = 0; bus.done_i = 0;
            if (cyc < 3) begin
                bus.host_we_i = 1;
                bus.host_ch_i = (cyc == 2) ? 2'd3 : 2'(cyc);
                bus.host_data_i = $urandom | 32'h1;
            end else if (grants.size() == 3 && !rearmed && bus.busy_o == '0) begin
                bus.host_we_i = 1; bus.host_ch_i = 2'd0; bus.host_data_i = 32'h0000_0011;
                rearmed = 1;
            end
            if (cnt == 0) bus.done_i = 1;
            step();
            if (cnt >= 0) cnt--;
            if (bus.start_valid_o) begin
                grants.push_back(int'(bus.start_ch_o));
                cnt = 3;
            end
        end
        check("t2_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size() && i < 4; i++) check("t2_grant", 32'(grants[i]), 32'(exp_order[i]));
        drain();

        // Rejected host writes
        bus.start_ready_i = 0;
        bus.host_we_i = 1; bus.host_ch_i = 2'd1; bus.host_data_i = 32'h0000_0051;
        step();
        bus.host_data_i = 32'h0000_1FF1;
        step();
        check("t3_err", 32'(bus.host_err_o), 32'h1);
        bus.host_we_i = 0; bus.rd_ch_i = 2'd1;
        step();
        check("t3_err_pulse", 32'(bus.host_err_o), 32'h0);
        check("t3_reg_keep", bus.rd_data_o, 32'h0000_0051);
        drain();

        bus3.host_we_i = 1; bus3.host_ch_i = 2'd3; bus3.host_data_i = 32'h0000_0001;
        step();
        check("oor_err", 32'(bus3.host_err_o), 32'h1);
        check("oor_busy", 32'(bus3.busy_o), 32'h0);
        bus3.host_we_i = 0; bus3.rd_ch_i = 2'd3;
        bus3.spi_we_i = 1; bus3.spi_ch_i = 2'd3; bus3.spi_data_i = 32'h0155_0000;
        step();
        check("oor_rd", bus3.rd_data_o, 32'h0);
        check("oor_err_clr", 32'(bus3.host_err_o), 32'h0);
        bus3.spi_we_i = 0;

        // Same-cycle host and engine write
        bus.host_we_i = 1; bus.host_ch_i = 2'd0; bus.host_data_i = 32'h0000_0010;
        bus.spi_we_i = 1; bus.spi_ch_i = 2'd0; bus.spi_data_i = 32'h0155_0000;
        step();
        idle_inputs();
        step();
        check("t4_merge", bus.rd_data_o, 32'h0155_0010);

        // Offer snapshot held while the engine writes
        bus.host_we_i = 1; bus.host_ch_i = 2'd2; bus.host_data_i = 32'h0000_00C5;
        step();
        bus.host_we_i = 0;
        n = 0;
        while (!bus.start_valid_o && n < 10) begin
            step();
            n++;
        end
        check("t5_offer", 32'(bus.start_valid_o), 32'h1);
        for (int k = 0; k < 5; k++) begin
            bus.spi_we_i = 1; bus.spi_ch_i = 2'd2; bus.spi_data_i = $urandom;
            step();
            check("t5_valid", 32'(bus.start_valid_o), 32'h1);
            check("t5_ch", 32'(bus.start_ch_o), 32'h2);
            check("t5_cfg", bus.start_cfg_o, 32'h0000_00C5);
        end
        drain();

        // Asynchronous reset while a channel is active
        bus.host_we_i = 1; bus.host_ch_i = 2'd1; bus.host_data_i = 32'h0000_0003;
        step();
        bus.host_we_i = 0; bus.start_ready_i = 1; bus.rd_ch_i = 2'd1;
        step();
        step();
        check("t6_active", 32'(bus.busy_o), 32'h2);
        #20 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(bus.busy_o), 32'h0);
        check("t6_rst_valid", 32'(bus.start_valid_o), 32'h0);
        check("t6_rst_rd", bus.rd_data_o, 32'h0);
        check("t6_rst_done", 32'(bus.done_o), 32'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        bus.done_i = 1;
        step();
        check("t6_done_ignored", 32'(bus.done_o), 32'h0);
        bus.done_i = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.host_we_i     = ($urandom_range(0, 3) == 0);
            bus.host_ch_i     = 2'($urandom_range(0, 3));
            bus.host_data_i   = $urandom;
            bus.spi_we_i      = ($urandom_range(0, 3) == 0);
            bus.spi_ch_i      = 2'($urandom_range(0, 3));
            bus.spi_data_i    = $urandom;
            bus.start_ready_i = $urandom_range(0, 1) == 1;
            bus.done_i        = ($urandom_range(0, 5) == 0);
            bus.rd_ch_i       = 2'($urandom_range(0, 3));
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
